// File: rtl/slink_crc_append.sv
// rtl/slink_crc_append.sv - payload forwarder that appends the CRC-16 trailer (LSB first) after the last byte
// Optional macro SLINK_CRC_APPEND_ERR_INJ_EN adds crc_err_inject to corrupt bit 0 of the next trailer.
module slink_crc_append #(
  parameter bit APPEND_CRC = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [15:0] i_data,
  input  logic [1:0]  i_byte_en,
  input  logic        i_eop,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [15:0] o_data,
  output logic [1:0]  o_byte_en,
  output logic        o_eop,
  output logic [15:0] crc_data_in,
  output logic [1:0]  crc_valid,
  output logic        crc_init,
  input  logic [15:0] crc_next
`ifdef SLINK_CRC_APPEND_ERR_INJ_EN
  ,
  input  logic        crc_err_inject
`endif
);

  typedef enum logic [1:0] {
    PAYLOAD  = 2'd0,
    CRC_FULL = 2'd1,
    CRC_HI   = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] hold_q, hold_nxt;
  logic        valid_nxt, eop_nxt;
  logic [15:0] data_nxt;
  logic [1:0]  be_nxt;
  logic        out_load;
  logic        accept;

  assign out_load = !o_valid || o_ready;
  assign i_ready  = (state == PAYLOAD) && out_load;
  assign accept   = i_valid && i_ready;

  // The compute block sees every accepted beat; init on eop reseeds it for the next packet.
  assign crc_data_in = APPEND_CRC ? i_data : 16'h0000;
  assign crc_valid   = (APPEND_CRC && accept) ? i_byte_en : 2'b00;
  assign crc_init    = APPEND_CRC && accept && i_eop;

`ifdef SLINK_CRC_APPEND_ERR_INJ_EN
  logic inj;
  // Sticky until the corrupted CRC byte0 is committed on the eop beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) inj <= 1'b0;
    else          inj <= crc_err_inject || (inj && !(APPEND_CRC && accept && i_eop));
  end
`else
  localparam logic inj = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_q;
    valid_nxt = o_valid;
    data_nxt  = o_data;
    be_nxt    = o_byte_en;
    eop_nxt   = o_eop;
    if (out_load) begin
      valid_nxt = 1'b0;
      case (state)
        PAYLOAD: begin
          if (accept) begin
            valid_nxt = 1'b1;
            data_nxt  = i_data;
            be_nxt    = i_byte_en;
            eop_nxt   = APPEND_CRC ? 1'b0 : i_eop;
            if (APPEND_CRC && i_eop) begin
              if (i_byte_en == 2'b01) begin
                // Odd length: CRC low byte fills the empty upper lane of this beat.
                data_nxt  = {crc_next[7:1], crc_next[0] ^ inj, i_data[7:0]};
                be_nxt    = 2'b11;
                hold_nxt  = {8'h00, crc_next[15:8]};
                state_nxt = CRC_HI;
              end else begin
                hold_nxt  = crc_next ^ {15'd0, inj};
                state_nxt = CRC_FULL;
              end
            end
          end
        end
        CRC_FULL: begin
          valid_nxt = 1'b1;
          data_nxt  = hold_q;
          be_nxt    = 2'b11;
          eop_nxt   = 1'b1;
          state_nxt = PAYLOAD;
        end
        CRC_HI: begin
          valid_nxt = 1'b1;
          data_nxt  = {8'h00, hold_q[7:0]};
          be_nxt    = 2'b01;
          eop_nxt   = 1'b1;
          state_nxt = PAYLOAD;
        end
        default: state_nxt = PAYLOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= PAYLOAD;
      hold_q    <= 16'h0000;
      o_valid   <= 1'b0;
      o_data    <= 16'h0000;
      o_byte_en <= 2'b00;
      o_eop     <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_q    <= hold_nxt;
      o_valid   <= valid_nxt;
      o_data    <= data_nxt;
      o_byte_en <= be_nxt;
      o_eop     <= eop_nxt;
    end
  end

endmodule

// File: tb/tb_slink_crc_append.sv
// tb/tb_slink_crc_append.sv - scoreboard bench for slink_crc_append with a CRC-16/MCRF4XX compute model
// Exercises crc_err_inject when SLINK_CRC_APPEND_ERR_INJ_EN is defined.
module tb_slink_crc_append;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_valid;
  logic        i_ready;
  logic [15:0] i_data;
  logic [1:0]  i_byte_en;
  logic        i_eop;
  logic        o_valid;
  logic        o_ready = 1'b1;
  logic [15:0] o_data;
  logic [1:0]  o_byte_en;
  logic        o_eop;
  logic [15:0] crc_data_in;
  logic [1:0]  crc_valid;
  logic        crc_init;
  logic [15:0] crc_next;
`ifdef SLINK_CRC_APPEND_ERR_INJ_EN
  logic        crc_err_inject = 1'b0;
`endif

  slink_crc_append #(.APPEND_CRC(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data), .i_byte_en(i_byte_en), .i_eop(i_eop),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_byte_en(o_byte_en), .o_eop(o_eop),
    .crc_data_in(crc_data_in), .crc_valid(crc_valid), .crc_init(crc_init), .crc_next(crc_next)
`ifdef SLINK_CRC_APPEND_ERR_INJ_EN
    , .crc_err_inject(crc_err_inject)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] g [0:23] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h1E, 8'hF0, 8'h1E, 8'hC7,
                           8'h4F, 8'h82, 8'h78, 8'hC5, 8'h82, 8'hE0, 8'h8C, 8'h70,
                           8'hD2, 8'h3C, 8'h78, 8'hE9, 8'hFF, 8'h00, 8'h00, 8'h01};

  function automatic logic [15:0] crc_byte(logic [15:0] c, logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction

  // CRC compute block model: combinational crc_next, init has priority over update.
  logic [15:0] crc_reg;
  always_comb begin
    crc_next = crc_reg;
    if (crc_valid[0]) crc_next = crc_byte(crc_next, crc_data_in[7:0]);
    if (crc_valid[1]) crc_next = crc_byte(crc_next, crc_data_in[15:8]);
  end
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)        crc_reg <= 16'hFFFF;
    else if (crc_init)   crc_reg <= 16'hFFFF;
    else if (|crc_valid) crc_reg <= crc_next;
  end

  always @(posedge clk) begin
    if (reset_n && i_valid && i_ready)
      assert (i_byte_en == 2'b11 || (i_byte_en == 2'b01 && i_eop)) else $error("illegal input beat");
  end

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  be;
    logic        eop;
  } beat_t;
  beat_t sb[$];

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Backpressure source: only writer of o_ready.
  logic bp_en = 1'b0;
  initial begin
    forever begin
      @(posedge clk); #1;
      o_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  int    cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on each handshake and checks stall stability.
  logic  gap_chk = 1'b0;
  int    last_hs = 0;
  logic  prev_stall = 1'b0;
  beat_t prev_beat;
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", 32'(o_valid), 32'd1);
          chk("stall_beat", 32'({o_data, o_byte_en, o_eop}), 32'(prev_beat));
        end
        if (o_valid && o_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_beat", 32'({o_data, o_byte_en, o_eop}), 32'hFFFFFFFF);
          end else begin
            e = sb.pop_front();
            chk("o_data", 32'(o_data), 32'(e.d));
            chk("o_byte_en", 32'(o_byte_en), 32'(e.be));
            chk("o_eop", 32'(o_eop), 32'(e.eop));
            if (gap_chk && e.eop) chk("trailer_gap", 32'(cyc - last_hs), 32'd1);
          end
          last_hs = cyc;
        end
        prev_stall = o_valid && !o_ready;
        prev_beat  = {o_data, o_byte_en, o_eop};
      end
    end
  end

  task automatic send_beat(logic [15:0] d, logic [1:0] be, logic eop);
    int t = 0;
    i_valid = 1'b1; i_data = d; i_byte_en = be; i_eop = eop;
    @(negedge clk);
    while (!i_ready && t < 200) begin @(negedge clk); t++; end
    if (!i_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: i_ready still %b after %0d cycles", i_ready, t);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    i_valid = 1'b0; i_eop = 1'b0;
  endtask

  // Sends the first nbytes of g; exp_crc is the required trailer value.
  task automatic send_pkt(int nbytes, logic [15:0] exp_crc);
    int nb = (nbytes + 1) / 2;
    for (int b = 0; b < nb; b++) begin
      logic last = (b == nb - 1);
      logic odd  = last && (nbytes % 2 == 1);
      logic [15:0] d = odd ? {8'h00, g[2*b]} : {g[2*b+1], g[2*b]};
      if (!last) begin
        sb.push_back('{d, 2'b11, 1'b0});
      end else if (odd) begin
        sb.push_back('{{exp_crc[7:0], g[2*b]}, 2'b11, 1'b0});
        sb.push_back('{{8'h00, exp_crc[15:8]}, 2'b01, 1'b1});
      end else begin
        sb.push_back('{d, 2'b11, 1'b0});
        sb.push_back('{exp_crc, 2'b11, 1'b1});
      end
      send_beat(d, odd ? 2'b01 : 2'b11, last);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 500) begin @(posedge clk); t++; end
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  function automatic logic [15:0] model_crc(int n);
    logic [15:0] c = 16'hFFFF;
    for (int i = 0; i < n; i++) c = crc_byte(c, g[i]);
    return c;
  endfunction

  initial begin
    reset_n = 1'b0; i_valid = 1'b0; i_data = 16'h0; i_byte_en = 2'b00; i_eop = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_o_data", 32'(o_data), 32'd0);
    chk("rst_o_byte_en", 32'(o_byte_en), 32'd0);
    chk("rst_o_eop", 32'(o_eop), 32'd0);
    chk("rst_crc_valid", 32'(crc_valid), 32'd0);
    chk("rst_crc_init", 32'(crc_init), 32'd0);
    chk("rst_i_ready", 32'(i_ready), 32'd1);
    @(posedge clk); #1;

    // Golden even-length packet, no backpressure.
    gap_chk = 1'b1;
    send_pkt(24, 16'hE569);
    idle();
    drain();

    // Odd-length packet (23 bytes).
    send_pkt(23, model_crc(23));
    idle();
    drain();
    gap_chk = 1'b0;

    // Random backpressure on the golden packet.
    bp_en = 1'b1;
    send_pkt(24, 16'hE569);
    idle();
    drain();
    bp_en = 1'b0;
    @(posedge clk); #1;

    // Back-to-back golden packets, i_valid held high across the boundary.
    gap_chk = 1'b1;
    send_pkt(24, 16'hE569);
    send_pkt(24, 16'hE569);
    idle();
    drain();
    gap_chk = 1'b0;

    // Reset after beat 5, then resend the golden packet.
    for (int b = 0; b < 5; b++) begin
      sb.push_back('{{g[2*b+1], g[2*b]}, 2'b11, 1'b0});
      send_beat({g[2*b+1], g[2*b]}, 2'b11, 1'b0);
    end
    idle();
    reset_n = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midrst_o_valid", 32'(o_valid), 32'd0);
    @(negedge clk);
    chk("midrst_o_valid2", 32'(o_valid), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    send_pkt(24, 16'hE569);
    idle();
    drain();

`ifdef SLINK_CRC_APPEND_ERR_INJ_EN
    crc_err_inject = 1'b1;
    @(posedge clk); #1;
    crc_err_inject = 1'b0;
    send_pkt(24, 16'hE568);
    idle();
    drain();
    send_pkt(24, 16'hE569);
    idle();
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, time %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
